multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multicycle sequencer for the RV32I datapath.
- Takes the decoder's one-hot instruction class `CODE` and steps the shared datapath through fetch, decode, execute, memory and writeback phases.
- Drives the datapath select and enable signals: ALU operand selects, register write, PC update, IR/MDR latches.
- Handshakes with one unified memory port; traps on illegal classes and memory timeouts.

Parameters:
- MEM_TIMEOUT, 16, max cycles `mem_req` may stay high without `mem_ready` before a trap (range 1..255).
- TO_W, 8, width of the wait counter; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `CODE`  in  10  one-hot instruction class: bit0 J, 1 JALR, 2 LUI, 3 AUIPC, 4 B, 5 R, 6 S, 7 I_ALU, 8 I_LOAD, 9 I_CSR.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `branch_taken`  in  1  branch comparator result, valid in EXECUTE.
- `mem_req`  out  1  memory request; held until `mem_ready`.
- `mem_we`  out  1  write strobe, qualified by `mem_req`.
- `mem_addr_sel`  out  1  0 = PC, 1 = ALUOut.
- `ir_write`  out  1  latch the instruction register.
- `mdr_write`  out  1  latch load data.
- `alu_sel_A`  out  1  0 = rs1, 1 = PC.
- `alu_sel_B`  out  1  0 = rs2, 1 = immediate.
- `reg_write`  out  1  register file write enable.
- `wb_sel`  out  2  00 ALUOut, 01 MDR, 10 PC+4, 11 immediate.
- `pc_write`  out  1  PC update enable.
- `pc_sel`  out  1  0 = PC+4, 1 = ALUOut.
- `instr_done`  out  1  one-cycle retire pulse.
- `trap`  out  1  sticky halt indicator.
- `trap_cause`  out  2  00 none, 01 non-one-hot `CODE`, 10 CSR unsupported, 11 memory timeout.
- `state`  out  3  current state, for debug.

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, TRAP=6.
- Reset (`reset`=0, async):
  - state=IDLE, `code_q`=0, wait counter=0, `trap_cause`=00.
  - All outputs are 0 during reset.
- IDLE: goes to FETCH on the first clock after reset deasserts. No outputs asserted.
- FETCH:
  - `mem_req`=1, `mem_addr_sel`=0.
  - On `mem_ready`: `ir_write`=1 in that same cycle, next state DECODE.
  - Zero-wait memory means one cycle in FETCH.
- DECODE:
  - `code_q` <= `CODE`.
  - Popcount(`CODE`)≠1 -> TRAP, cause 01.
  - I_CSR -> TRAP, cause 10.
  - LUI -> WRITEBACK.
  - All other classes -> EXECUTE.
- EXECUTE (decoded from `code_q`; later `CODE` changes are ignored):
  - `alu_sel_A`=1 for J and AUIPC, else 0.
  - `alu_sel_B`=0 for R and B, else 1.
  - B: `pc_write`=1, `pc_sel`=`branch_taken`, `instr_done`=1, next state FETCH.
  - S and I_LOAD -> MEM.
  - All others -> WRITEBACK.
- MEM:
  - `mem_req`=1, `mem_addr_sel`=1, `mem_we`=1 for S.
  - On `mem_ready` for S: `pc_write`=1, `pc_sel`=0, `instr_done`=1, next state FETCH.
  - On `mem_ready` for I_LOAD: `mdr_write`=1, next state WRITEBACK.
- WRITEBACK:
  - `reg_write`=1, `pc_write`=1, `instr_done`=1, next state FETCH.
  - `wb_sel`: LUI=11, I_LOAD=01, J and JALR=10, else 00.
  - `pc_sel`=1 for J and JALR, else 0.
- TRAP:
  - `trap`=1, `trap_cause` held.
  - All other outputs 0; leaves only by reset.
- Wait counter:
  - Clears on entry to FETCH or MEM; increments each cycle `mem_req`=1 and `mem_ready`=0.
  - If it reaches MEM_TIMEOUT with `mem_ready` still 0 -> TRAP, cause 11, and `mem_req` drops the next cycle.
  - `mem_ready` in the same cycle the count hits MEM_TIMEOUT: completion wins, no trap.
- `mem_ready` outside FETCH/MEM is ignored.
- `alu_sel_A`/`alu_sel_B` are 0 outside EXECUTE.
- All outputs are combinational from state, `code_q`, `mem_ready` and `branch_taken`.
- Cycles per instruction at zero wait (FETCH to FETCH):
  - B: 3. LUI: 3.
  - R, I_ALU, AUIPC, J, JALR: 4. S: 4.
  - I_LOAD: 5.
- Reset mid-operation: abort immediately. `mem_req` falls asynchronously; no `reg_write` or `pc_write` is issued.

Decomposition:
- Shared package `ctrl_pkg`:
  - state encodings
  - `CODE` bit indices (CODE_J … CODE_CSR)
  - `wb_sel` constants (WB_ALU, WB_MEM, WB_PC4, WB_IMM)
  - `trap_cause` constants
- Sub-module `mem_wait_timer`: clear/enable inputs, `timeout` output, parameterized by MEM_TIMEOUT and TO_W.

Test Plan:
- R-type (`CODE`=10'b0000100000), `mem_ready` tied 1:
  - `state` sequence 1,2,3,5,1.
  - `alu_sel_B`=0 in EXECUTE.
  - `reg_write`=1 with `wb_sel`=00 in WRITEBACK.
  - `instr_done` pulses once, 4 cycles after FETCH entry.
- I_LOAD (10'b0100000000), memory with 2 wait cycles on each access:
  - `mem_req` high 3 cycles per access.
  - `mdr_write`=1 only in the MEM cycle where `mem_ready`=1.
  - `wb_sel`=01; total 9 cycles.
- B (10'b0000010000): with `branch_taken`=1 -> `pc_write`=1, `pc_sel`=1 in EXECUTE, no `reg_write`, 3 cycles. Repeat with `branch_taken`=0 -> `pc_sel`=0.
- Illegal classes:
  - `CODE`=10'b0000100001 -> TRAP, cause 01.
  - `CODE`=10'b1000000000 -> TRAP, cause 10.
  - In both cases `trap` stays 1 for 20 cycles and all enables stay 0.
- MEM_TIMEOUT=4, `mem_ready`=0 in FETCH -> TRAP, cause 11, after 4 request cycles. Separately, `mem_ready` on the 4th cycle -> DECODE with no trap.
- Drop `reset` mid-MEM during a store:
  - `mem_req`/`mem_we` fall within the same cycle, and `state`=0.
  - After release, IDLE for 1 cycle, then FETCH.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV32I multicycle sequencer: states, instruction
// class bit positions, writeback selects and trap causes.
package ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_MEM       = 3'd4,
      S_WRITEBACK = 3'd5,
      S_TRAP      = 3'd6
   } state_t;

   localparam int CODE_W      = 10;
   localparam int CODE_J      = 0;
   localparam int CODE_JALR   = 1;
   localparam int CODE_LUI    = 2;
   localparam int CODE_AUIPC  = 3;
   localparam int CODE_B      = 4;
   localparam int CODE_R      = 5;
   localparam int CODE_S      = 6;
   localparam int CODE_I_ALU  = 7;
   localparam int CODE_I_LOAD = 8;
   localparam int CODE_CSR    = 9;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;
   localparam logic [1:0] WB_IMM = 2'b11;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ONEHOT  = 2'b01;
   localparam logic [1:0] CAUSE_CSR     = 2'b10;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

   function automatic logic is_one_hot(input logic [CODE_W-1:0] code);
      return (code != '0) && ((code & (code - 1'b1)) == '0);
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Unified memory port between the sequencer (master) and the memory (slave).
interface multicycle_ctrl_if;
   logic mem_req;
   logic mem_we;
   logic mem_addr_sel;
   logic mem_ready;

   modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ready);
   modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ready);
endinterface

// File: rtl/mem_wait_timer.sv
// Counts stalled memory request cycles; flags the cycle in which the stall
// would reach MEM_TIMEOUT so the sequencer can trap on the following edge.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 16,
   parameter int TO_W        = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic en,
   output logic timeout
);

   logic [TO_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (en) begin
         count <= count + 1'b1;
      end
   end

   // A ready in the same cycle suppresses en, so completion beats timeout.
   assign timeout = en && (count == TO_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer stepping the shared RV32I datapath through
// fetch/decode/execute/mem/writeback, with sticky trap on errors.
//
// state      | meaning
// IDLE       | one cycle after reset release, nothing driven
// FETCH      | read instruction at PC, latch IR on ready
// DECODE     | capture CODE, route by class or trap
// EXECUTE    | ALU operation; branches retire here
// MEM        | load/store at ALUOut; stores retire here
// WRITEBACK  | register write and PC update, retire
// TRAP       | sticky halt until reset
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int TO_W        = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [CODE_W-1:0]      CODE,
   input  logic                   branch_taken,
   multicycle_ctrl_if.master      mem,
   output logic                   ir_write,
   output logic                   mdr_write,
   output logic                   alu_sel_A,
   output logic                   alu_sel_B,
   output logic                   reg_write,
   output logic [1:0]             wb_sel,
   output logic                   pc_write,
   output logic                   pc_sel,
   output logic                   instr_done,
   output logic                   trap,
   output logic [1:0]             trap_cause,
   output logic [2:0]             state
);

   state_t              cur_state;
   state_t              state_nxt;
   logic [CODE_W-1:0]   code_q;
   logic [1:0]          cause_q;
   logic [1:0]          cause_nxt;
   logic                req;
   logic                we;
   logic                addr_sel;
   logic                timer_en;
   logic                timer_clear;
   logic                timeout;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur_state <= S_IDLE;
         code_q    <= '0;
         cause_q   <= CAUSE_NONE;
      end else begin
         cur_state <= state_nxt;
         cause_q   <= cause_nxt;
         if (cur_state == S_DECODE) begin
            code_q <= CODE;
         end
      end
   end

   // Derived from state alone so the timer does not loop back through req.
   assign timer_en    = ((cur_state == S_FETCH) || (cur_state == S_MEM)) && !mem.mem_ready;
   assign timer_clear = (state_nxt != cur_state);

   mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .TO_W        (TO_W)
   ) u_mem_wait_timer (
      .clk     (clk),
      .rst_n   (reset),
      .clear   (timer_clear),
      .en      (timer_en),
      .timeout (timeout)
   );

   always_comb begin
      state_nxt  = cur_state;
      cause_nxt  = cause_q;
      req        = 1'b0;
      we         = 1'b0;
      addr_sel   = 1'b0;
      ir_write   = 1'b0;
      mdr_write  = 1'b0;
      alu_sel_A  = 1'b0;
      alu_sel_B  = 1'b0;
      reg_write  = 1'b0;
      wb_sel     = WB_ALU;
      pc_write   = 1'b0;
      pc_sel     = 1'b0;
      instr_done = 1'b0;
      trap       = 1'b0;

      case (cur_state)
         S_IDLE: begin
            state_nxt = S_FETCH;
         end
         S_FETCH: begin
            req = 1'b1;
            if (mem.mem_ready) begin
               ir_write  = 1'b1;
               state_nxt = S_DECODE;
            end else if (timeout) begin
               state_nxt = S_TRAP;
               cause_nxt = CAUSE_TIMEOUT;
            end
         end
         S_DECODE: begin
            if (!is_one_hot(CODE)) begin
               state_nxt = S_TRAP;
               cause_nxt = CAUSE_ONEHOT;
            end else if (CODE[CODE_CSR]) begin
               state_nxt = S_TRAP;
               cause_nxt = CAUSE_CSR;
            end else if (CODE[CODE_LUI]) begin
               state_nxt = S_WRITEBACK;
            end else begin
               state_nxt = S_EXECUTE;
            end
         end
         S_EXECUTE: begin
            alu_sel_A = code_q[CODE_J] | code_q[CODE_AUIPC];
            alu_sel_B = !(code_q[CODE_R] | code_q[CODE_B]);
            if (code_q[CODE_B]) begin
               pc_write   = 1'b1;
               pc_sel     = branch_taken;
               instr_done = 1'b1;
               state_nxt  = S_FETCH;
            end else if (code_q[CODE_S] || code_q[CODE_I_LOAD]) begin
               state_nxt = S_MEM;
            end else begin
               state_nxt = S_WRITEBACK;
            end
         end
         S_MEM: begin
            req      = 1'b1;
            addr_sel = 1'b1;
            we       = code_q[CODE_S];
            if (mem.mem_ready) begin
               if (code_q[CODE_S]) begin
                  pc_write   = 1'b1;
                  instr_done = 1'b1;
                  state_nxt  = S_FETCH;
               end else begin
                  mdr_write = 1'b1;
                  state_nxt = S_WRITEBACK;
               end
            end else if (timeout) begin
               state_nxt = S_TRAP;
               cause_nxt = CAUSE_TIMEOUT;
            end
         end
         S_WRITEBACK: begin
            reg_write  = 1'b1;
            pc_write   = 1'b1;
            instr_done = 1'b1;
            pc_sel     = code_q[CODE_J] | code_q[CODE_JALR];
            if (code_q[CODE_LUI]) begin
               wb_sel = WB_IMM;
            end else if (code_q[CODE_I_LOAD]) begin
               wb_sel = WB_MEM;
            end else if (code_q[CODE_J] || code_q[CODE_JALR]) begin
               wb_sel = WB_PC4;
            end else begin
               wb_sel = WB_ALU;
            end
            state_nxt = S_FETCH;
         end
         S_TRAP: begin
            trap = 1'b1;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign mem.mem_req      = req;
   assign mem.mem_we       = we;
   assign mem.mem_addr_sel = addr_sel;
   assign trap_cause       = cause_q;
   assign state            = cur_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus random
// instruction streams compared against a per-instruction effect model.
module tb_multicycle_ctrl;
   import ctrl_pkg::*;

   localparam int TIMEOUT = 4;

   typedef struct packed {
      int cycles;
      int req;
      int we;
      int addr;
      int ir;
      int mdr;
      int mdr_bad;
      int regw;
      int pcw;
      int done;
      int alua;
      int alub;
      int trapseen;
      logic [1:0] wbsel;
      logic pcsel;
      logic ok;
   } stats_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [9:0] CODE = '0;
   logic       branch_taken = 1'b0;
   logic       ir_write, mdr_write, alu_sel_A, alu_sel_B, reg_write;
   logic [1:0] wb_sel;
   logic       pc_write, pc_sel, instr_done, trap;
   logic [1:0] trap_cause;
   logic [2:0] state;
   logic       any_en;

   int n_checks = 0;
   int n_fail   = 0;
   logic [2:0] trace[$];

   multicycle_ctrl_if mem_bus();

   multicycle_ctrl #(.MEM_TIMEOUT(TIMEOUT), .TO_W(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .CODE         (CODE),
      .branch_taken (branch_taken),
      .mem          (mem_bus.master),
      .ir_write     (ir_write),
      .mdr_write    (mdr_write),
      .alu_sel_A    (alu_sel_A),
      .alu_sel_B    (alu_sel_B),
      .reg_write    (reg_write),
      .wb_sel       (wb_sel),
      .pc_write     (pc_write),
      .pc_sel       (pc_sel),
      .instr_done   (instr_done),
      .trap         (trap),
      .trap_cause   (trap_cause),
      .state        (state)
   );

   always #5 clk = ~clk;

   assign any_en = mem_bus.mem_req | mem_bus.mem_we | mem_bus.mem_addr_sel | ir_write |
                   mdr_write | alu_sel_A | alu_sel_B | reg_write | (wb_sel != 2'b00) |
                   pc_write | pc_sel | instr_done;

   // Expected per-instruction effects from the class rules and wait counts.
   function automatic stats_t model(input int cls, input int fw, input int mw, input logic taken);
      stats_t e;
      bit is_b, is_s, is_ld, is_lui, is_link, uses_mem, has_wb;
      e       = '0;
      is_b    = (cls == CODE_B);
      is_s    = (cls == CODE_S);
      is_ld   = (cls == CODE_I_LOAD);
      is_lui  = (cls == CODE_LUI);
      is_link = (cls == CODE_J) || (cls == CODE_JALR);
      uses_mem = is_s || is_ld;
      has_wb   = !(is_b || is_s);
      e.cycles = (fw + 1) + 1 + (is_lui ? 0 : 1) + (uses_mem ? mw + 1 : 0) + (has_wb ? 1 : 0);
      e.req    = (fw + 1) + (uses_mem ? mw + 1 : 0);
      e.addr   = uses_mem ? mw + 1 : 0;
      e.we     = is_s ? mw + 1 : 0;
      e.ir     = 1;
      e.mdr    = is_ld ? 1 : 0;
      e.regw   = has_wb ? 1 : 0;
      e.pcw    = 1;
      e.done   = 1;
      e.alua   = ((cls == CODE_J) || (cls == CODE_AUIPC)) ? 1 : 0;
      e.alub   = (is_lui || is_b || (cls == CODE_R)) ? 0 : 1;
      if (!has_wb)     e.wbsel = 2'b00;
      else if (is_lui) e.wbsel = 2'b11;
      else if (is_ld)  e.wbsel = 2'b01;
      else if (is_link) e.wbsel = 2'b10;
      else             e.wbsel = 2'b00;
      e.pcsel  = is_b ? taken : is_link;
      e.ok     = 1'b1;
      return e;
   endfunction

   task automatic do_reset();
      reset = 1'b0;
      mem_bus.mem_ready = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   // Runs one instruction from FETCH; memory answers after fw/mw stall cycles.
   task automatic run_instr(input int cls, input int fw, input int mw, input logic taken,
                            input bit scramble, output stats_t s);
      int  acc, wctr, tgt;
      bit  fin, decoded;
      s = '0;
      acc = 0; wctr = 0; fin = 0; decoded = 0;
      trace.delete();
      CODE = 10'(1 << cls);
      branch_taken = taken;
      for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
         tgt = (acc == 0) ? fw : mw;
         if (mem_bus.mem_req) mem_bus.mem_ready = (wctr == tgt);
         else                 mem_bus.mem_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         trace.push_back(state);
         s.cycles++;
         if (mem_bus.mem_req)      s.req++;
         if (mem_bus.mem_we)       s.we++;
         if (mem_bus.mem_addr_sel) s.addr++;
         if (ir_write)             s.ir++;
         if (mdr_write) begin
            s.mdr++;
            if (!mem_bus.mem_ready) s.mdr_bad++;
         end
         if (reg_write) begin s.regw++; s.wbsel = wb_sel; end
         if (pc_write)  begin s.pcw++;  s.pcsel = pc_sel; end
         if (instr_done) s.done++;
         if (alu_sel_A)  s.alua++;
         if (alu_sel_B)  s.alub++;
         if (trap)       s.trapseen++;
         if (mem_bus.mem_req) begin
            if (mem_bus.mem_ready) begin acc++; wctr = 0; end
            else wctr++;
         end
         if (instr_done) fin = 1;
         if (state == 3'd2) decoded = 1;
         @(posedge clk); #1;
         if (scramble && decoded && !fin) CODE = 10'($urandom);
      end
      s.ok = fin;
      if (!fin) do_reset();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      mem_bus.mem_ready = 1'b1;
      CODE = 10'b1000000000;
      @(negedge clk);
      n_checks++;
      if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state); end
      n_checks++;
      if ((any_en | trap) !== 1'b0) begin n_fail++; $display("FAIL reset_outputs got=%b exp=0", any_en | trap); end
      n_checks++;
      if (trap_cause !== 2'b00) begin n_fail++; $display("FAIL reset_cause got=%b exp=00", trap_cause); end
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if (state !== 3'd0) begin n_fail++; $display("FAIL idle_after_release got=%0d exp=0", state); end
      @(posedge clk); #1;
      n_checks++;
      if (state !== 3'd1) begin n_fail++; $display("FAIL fetch_after_idle got=%0d exp=1", state); end
   endtask

   task automatic test_r_type();
      stats_t s;
      bit seq_ok;
      run_instr(CODE_R, 0, 0, 1'b0, 1'b0, s);
      seq_ok = (trace.size() == 4) && (trace[0] == 3'd1) && (trace[1] == 3'd2) &&
               (trace[2] == 3'd3) && (trace[3] == 3'd5);
      n_checks++;
      if (seq_ok !== 1'b1) begin n_fail++; $display("FAIL r_seq got=%p exp=1,2,3,5", trace); end
      n_checks++;
      if (state !== 3'd1) begin n_fail++; $display("FAIL r_next_fetch got=%0d exp=1", state); end
      n_checks++;
      if (s.alub !== 0) begin n_fail++; $display("FAIL r_alu_sel_B got=%0d exp=0", s.alub); end
      n_checks++;
      if (s.regw !== 1 || s.wbsel !== 2'b00) begin
         n_fail++; $display("FAIL r_writeback got regw=%0d wb=%b exp regw=1 wb=00", s.regw, s.wbsel);
      end
      n_checks++;
      if (s.done !== 1 || s.cycles !== 4) begin
         n_fail++; $display("FAIL r_retire got done=%0d cycles=%0d exp 1/4", s.done, s.cycles);
      end
   endtask

   task automatic test_load_wait();
      stats_t s;
      run_instr(CODE_I_LOAD, 2, 2, 1'b0, 1'b0, s);
      n_checks++;
      if (s.cycles !== 9) begin n_fail++; $display("FAIL load_cycles got=%0d exp=9", s.cycles); end
      n_checks++;
      if (s.req !== 6) begin n_fail++; $display("FAIL load_req_cycles got=%0d exp=6", s.req); end
      n_checks++;
      if (s.mdr !== 1 || s.mdr_bad !== 0) begin
         n_fail++; $display("FAIL load_mdr got=%0d bad=%0d exp 1/0", s.mdr, s.mdr_bad);
      end
      n_checks++;
      if (s.wbsel !== 2'b01 || s.regw !== 1) begin
         n_fail++; $display("FAIL load_wb got wb=%b regw=%0d exp 01/1", s.wbsel, s.regw);
      end
   endtask

   task automatic test_branch();
      stats_t s;
      for (int t = 1; t >= 0; t--) begin
         run_instr(CODE_B, 0, 0, 1'(t), 1'b0, s);
         n_checks++;
         if (s.cycles !== 3 || s.pcw !== 1 || s.regw !== 0) begin
            n_fail++;
            $display("FAIL branch_%0d got cycles=%0d pcw=%0d regw=%0d exp 3/1/0", t, s.cycles, s.pcw, s.regw);
         end
         n_checks++;
         if (s.pcsel !== 1'(t)) begin n_fail++; $display("FAIL branch_pc_sel_%0d got=%b exp=%0d", t, s.pcsel, t); end
      end
   endtask

   task automatic test_illegal();
      logic [9:0] codes [2];
      logic [1:0] causes[2];
      int found, bad;
      codes[0] = 10'b0000100001; causes[0] = 2'b01;
      codes[1] = 10'b1000000000; causes[1] = 2'b10;
      for (int k = 0; k < 2; k++) begin
         CODE = codes[k];
         mem_bus.mem_ready = 1'b1;
         found = 0;
         for (int c = 1; c <= 10 && found == 0; c++) begin
            @(negedge clk);
            if (trap) found = c;
            @(posedge clk); #1;
         end
         n_checks++;
         if (found !== 3 || trap_cause !== causes[k]) begin
            n_fail++;
            $display("FAIL illegal_%0d got at=%0d cause=%b exp at=3 cause=%b", k, found, trap_cause, causes[k]);
         end
         bad = 0;
         for (int c = 0; c < 20; c++) begin
            mem_bus.mem_ready = 1'($urandom_range(0, 1));
            CODE = 10'($urandom);
            @(negedge clk);
            if (trap !== 1'b1 || any_en !== 1'b0 || state !== 3'd6 || trap_cause !== causes[k]) bad++;
            @(posedge clk); #1;
         end
         n_checks++;
         if (bad !== 0) begin n_fail++; $display("FAIL illegal_hold_%0d got bad_cycles=%0d exp=0", k, bad); end
         do_reset();
      end
   endtask

   task automatic test_timeout();
      stats_t s;
      int reqs;
      bit seen;
      CODE = 10'b0000100000;
      mem_bus.mem_ready = 1'b0;
      reqs = 0; seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (trap) seen = 1;
         else if (mem_bus.mem_req) reqs++;
         @(posedge clk); #1;
      end
      n_checks++;
      if (seen !== 1'b1 || reqs !== TIMEOUT || trap_cause !== 2'b11) begin
         n_fail++;
         $display("FAIL timeout_trap got seen=%0d reqs=%0d cause=%b exp 1/%0d/11", seen, reqs, trap_cause, TIMEOUT);
      end
      n_checks++;
      if (mem_bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL timeout_req_drop got=%b exp=0", mem_bus.mem_req); end
      do_reset();
      run_instr(CODE_I_ALU, TIMEOUT - 1, 0, 1'b0, 1'b0, s);
      n_checks++;
      if (s.ok !== 1'b1 || s.trapseen !== 0 || s.cycles !== TIMEOUT + 3) begin
         n_fail++;
         $display("FAIL timeout_edge got ok=%b trap=%0d cycles=%0d exp 1/0/%0d", s.ok, s.trapseen, s.cycles, TIMEOUT + 3);
      end
      n_checks++;
      if (trace.size() < 5 || trace[TIMEOUT] !== 3'd2) begin
         n_fail++; $display("FAIL timeout_edge_decode got=%p", trace);
      end
   endtask

   task automatic test_reset_mid_store();
      bit in_mem;
      CODE = 10'b0001000000;
      in_mem = 0;
      for (int c = 0; c < 10 && !in_mem; c++) begin
         mem_bus.mem_ready = (state == 3'd1);
         @(negedge clk);
         if (state == 3'd4) in_mem = 1;
         else begin @(posedge clk); #1; end
      end
      n_checks++;
      if (in_mem !== 1'b1 || mem_bus.mem_we !== 1'b1 || mem_bus.mem_req !== 1'b1) begin
         n_fail++;
         $display("FAIL store_mem got in_mem=%0d we=%b req=%b exp 1/1/1", in_mem, mem_bus.mem_we, mem_bus.mem_req);
      end
      #2;
      reset = 1'b0;
      #1;
      n_checks++;
      if (mem_bus.mem_req !== 1'b0 || mem_bus.mem_we !== 1'b0 || state !== 3'd0 ||
          reg_write !== 1'b0 || pc_write !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_async got req=%b we=%b state=%0d regw=%b pcw=%b exp 0/0/0/0/0",
                  mem_bus.mem_req, mem_bus.mem_we, state, reg_write, pc_write);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if (state !== 3'd0) begin n_fail++; $display("FAIL abort_idle got=%0d exp=0", state); end
      @(posedge clk); #1;
      n_checks++;
      if (state !== 3'd1) begin n_fail++; $display("FAIL abort_fetch got=%0d exp=1", state); end
   endtask

   task automatic test_back_to_back_random();
      stats_t s, e;
      int cls, fw, mw;
      logic taken;
      for (int n = 0; n < 30; n++) begin
         cls   = $urandom_range(0, 8);
         fw    = $urandom_range(0, TIMEOUT - 1);
         mw    = $urandom_range(0, TIMEOUT - 1);
         taken = 1'($urandom_range(0, 1));
         e = model(cls, fw, mw, taken);
         run_instr(cls, fw, mw, taken, 1'b1, s);
         n_checks++;
         if (s !== e) begin
            n_fail++;
            $display("FAIL rand_%0d cls=%0d fw=%0d mw=%0d t=%b got=%h exp=%h", n, cls, fw, mw, taken, s, e);
         end
      end
   endtask

   initial begin
      mem_bus.mem_ready = 1'b0;
      test_reset();
      test_r_type();
      test_load_wait();
      test_branch();
      test_illegal();
      test_timeout();
      test_reset_mid_store();
      test_back_to_back_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=expired exp=finished");
      $fatal(1, "watchdog");
   end

endmodule
